// File: rtl/regfile_loader.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_loader
//  Purpose  : Streams NREGS words over valid/ready into the register-file write
//             port and holds the core stalled until the pass completes.
//  Option   : LOADER_CHECKSUM_EN adds a CHECK state that takes one trailing
//             XOR-checksum beat and flags a mismatch on err.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_loader #(
    parameter int width = 16,
    parameter int NREGS = 4,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             s_valid_i,
    input  logic [width-1:0] s_data_i,
    output logic             s_ready_o,
    output logic             rf_we_o,
    output logic [AW-1:0]    rf_waddr_o,
    output logic [width-1:0] rf_wdata_o,
    output logic             core_hold_o,
    output logic             done_o,
    output logic             err_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One spare count bit keeps the address from wrapping inside a pass.
    localparam logic [AW:0] c_LAST_IDX = (AW+1)'(NREGS - 1);

    state_t           state_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             rf_we_q;
    logic [AW-1:0]    rf_waddr_q;
    logic [width-1:0] rf_wdata_q;
    logic             core_hold_q;
    logic             done_q;
    logic             w_beat;
    logic             w_last;

`ifdef LOADER_CHECKSUM_EN
    logic [width-1:0] xor_q;
    logic             err_q;

    assign s_ready_o = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign err_o     = err_q;
`else
    assign s_ready_o = (state_q == ST_LOAD);
    assign err_o     = 1'b0;
`endif

    assign w_beat      = s_valid_i && s_ready_o;
    assign w_last      = (cnt_q == c_LAST_IDX);
    assign cnt_d       = cnt_q + 1'b1;

    assign rf_we_o     = rf_we_q;
    assign rf_waddr_o  = rf_waddr_q;
    assign rf_wdata_o  = rf_wdata_q;
    assign core_hold_o = core_hold_q;
    assign done_o      = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            core_hold_q <= 1'b1;
            done_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xor_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            rf_we_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q <= ST_LOAD;
                        cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
                        xor_q   <= '0;
`endif
                    end
                end
                ST_LOAD: begin
                    if (w_beat) begin
                        rf_we_q    <= 1'b1;
                        rf_waddr_q <= cnt_q[AW-1:0];
                        rf_wdata_q <= s_data_i;
                        cnt_q      <= cnt_d;
`ifdef LOADER_CHECKSUM_EN
                        xor_q      <= xor_q ^ s_data_i;
                        if (w_last) state_q <= ST_CHECK;
`else
                        if (w_last) state_q <= ST_DONE;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    if (w_beat) begin
                        if (s_data_i != xor_q) err_q <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
`endif
                ST_DONE: begin
                    if (start_i) begin
                        state_q     <= ST_LOAD;
                        cnt_q       <= '0;
                        done_q      <= 1'b0;
                        core_hold_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        xor_q       <= '0;
                        err_q       <= 1'b0;
`endif
                    end else begin
                        // Release lags the final write pulse by one cycle.
                        done_q      <= 1'b1;
                        core_hold_q <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_loader.sv
`default_nettype none
// Directed bench for regfile_loader: expected writes are queued as beats are
// driven and matched against rf_we pulses by a monitor.
module tb_regfile_loader;

    localparam int W     = 16;
    localparam int NREGS = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic          s_valid_i;
    logic [W-1:0]  s_data_i;
    logic          s_ready_o;
    logic          rf_we_o;
    logic [AW-1:0] rf_waddr_o;
    logic [W-1:0]  rf_wdata_o;
    logic          core_hold_o;
    logic          done_o;
    logic          err_o;

    regfile_loader #(.width(W), .NREGS(NREGS)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .s_valid_i   (s_valid_i),
        .s_data_i    (s_data_i),
        .s_ready_o   (s_ready_o),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o),
        .core_hold_o (core_hold_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        longint        t;
    } exp_t;

    exp_t          sb[$];
    int            checks = 0;
    int            errors = 0;
    logic [AW-1:0] exp_addr;
    logic [W-1:0]  words [NREGS];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each rf_we pulse must match the oldest queued beat and arrive one cycle after it.
    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1 && rf_we_o !== 1'b0) begin
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(rf_we_o), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("waddr", 32'(rf_waddr_o), 32'(e.a));
                check("wdata", 32'(rf_wdata_o), 32'(e.d));
                check("wtime", 32'($time), 32'(e.t));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] words_xor();
        logic [W-1:0] x = '0;
        for (int i = 0; i < NREGS; i++) x = x ^ words[i];
        return x;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_s_ready"},   32'(s_ready_o),   32'd0);
        check({tag, "_rf_we"},     32'(rf_we_o),     32'd0);
        check({tag, "_rf_waddr"},  32'(rf_waddr_o),  32'd0);
        check({tag, "_rf_wdata"},  32'(rf_wdata_o),  32'd0);
        check({tag, "_core_hold"}, 32'(core_hold_o), 32'd1);
        check({tag, "_done"},      32'(done_o),      32'd0);
        check({tag, "_err"},       32'(err_o),       32'd0);
    endtask

    // All tasks are entered and left just after a falling edge.
    task automatic pulse_start();
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        exp_addr = '0;
    endtask

    task automatic send(input logic [W-1:0] d, input bit write, input int gap);
        s_valid_i = 1'b1;
        s_data_i  = d;
        check("s_ready_on_beat", 32'(s_ready_o), 32'd1);
        if (write) begin
            sb.push_back('{a: exp_addr, d: d, t: longint'($time) + 6});
            exp_addr++;
        end
        @(negedge clk);
        s_valid_i = 1'b0;
        s_data_i  = W'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic finish_pass(input logic [W-1:0] chk);
        logic exp_err;
`ifdef LOADER_CHECKSUM_EN
        send(chk, 1'b0, 0);
        exp_err = (chk != words_xor());
`else
        exp_err = 1'b0;
`endif
        check("done_during_last_write", 32'(done_o), 32'd0);
        check("hold_during_last_write", 32'(core_hold_o), 32'd1);
        @(negedge clk);
        check("done_after",      32'(done_o),      32'd1);
        check("hold_after",      32'(core_hold_o), 32'd0);
        check("s_ready_done",    32'(s_ready_o),   32'd0);
        check("err_after",       32'(err_o),       32'(exp_err));
        check("writes_pending",  32'(sb.size()),   32'd0);
        check("wdata_held",      32'(rf_wdata_o),  32'(words[NREGS-1]));
        check("waddr_held",      32'(rf_waddr_o),  32'(NREGS-1));
    endtask

    task automatic load_pass(input int gap, input logic [W-1:0] chk);
        pulse_start();
        check("done_cleared",  32'(done_o),      32'd0);
        check("hold_on_start", 32'(core_hold_o), 32'd1);
        check("err_cleared",   32'(err_o),       32'd0);
        for (int i = 0; i < NREGS; i++) send(words[i], 1'b1, (i == NREGS-1) ? 0 : gap);
        finish_pass(chk);
    endtask

    initial begin
        rst_n     = 1'b0;
        start_i   = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_hold", 32'(core_hold_o), 32'd1);

        // Back-to-back load
        words = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        load_pass(0, 16'h0004);

        // Reset asserted mid-cycle takes effect without a clock edge
        #2 rst_n = 1'b0;
        #1 check_reset_vals("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Bubbles between beats
        words = '{16'hAAAA, 16'h5555, 16'hFFFF, 16'h0000};
        load_pass(2, 16'h0000);

        // Reset in the middle of a pass
        pulse_start();
        send(16'h0021, 1'b1, 0);
        send(16'h0022, 1'b1, 0);
        #2 rst_n = 1'b0;
        #1 check("midrst_hold", 32'(core_hold_o), 32'd1);
        check("midrst_s_ready", 32'(s_ready_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        check("midrst_pending", 32'(sb.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // s_valid in IDLE is ignored
        s_valid_i = 1'b1;
        s_data_i  = 16'hDEAD;
        @(negedge clk);
        check("idle_s_ready", 32'(s_ready_o), 32'd0);
        @(negedge clk);
        check("idle_still_hold", 32'(core_hold_o), 32'd1);
        s_valid_i = 1'b0;
        words = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
        load_pass(0, 16'h0000);

        // start with s_valid in IDLE, then start during LOAD
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        start_i   = 1'b1;
        s_valid_i = 1'b1;
        s_data_i  = 16'hBEEF;
        check("idle_start_s_ready", 32'(s_ready_o), 32'd0);
        @(negedge clk);
        start_i   = 1'b0;
        s_valid_i = 1'b0;
        exp_addr  = '0;
        words = '{16'h0031, 16'h0032, 16'h0033, 16'h0034};
        send(words[0], 1'b1, 0);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("load_start_ignored", 32'(s_ready_o), 32'd1);
        for (int i = 1; i < NREGS; i++) send(words[i], 1'b1, 0);
        finish_pass(16'h0004);

        // s_valid in DONE is ignored
        s_valid_i = 1'b1;
        s_data_i  = 16'h1234;
        @(negedge clk);
        @(negedge clk);
        s_valid_i = 1'b0;
        check("done_s_valid_done", 32'(done_o), 32'd1);
        check("done_s_valid_pending", 32'(sb.size()), 32'd0);

        // Restart from DONE; checksum good, bad, then good again
        words = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
        load_pass(0, 16'h0004);
        load_pass(0, 16'h0005);
        load_pass(1, 16'h0004);

        repeat (3) @(negedge clk);
        check("final_pending", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
